// File: rtl/a_equal_b_if.sv
// Operand/result bundle for the a_equal_b equality comparator.
// The master drives the operands and the capture enable; the slave (the
// comparator) returns the combinational result, the diagnostics and the
// registered status.
interface a_equal_b_if #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
);
  localparam int IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             en;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] diff;
  logic [IDX_W-1:0] diff_idx;
  logic             c_q;
  logic [WIDTH-1:0] diff_q;
  logic             valid_q;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] cmp_cnt;

  modport master (
    output A, B, en,
    input  C, diff, diff_idx, c_q, diff_q, valid_q, eq_cnt, cmp_cnt
  );

  modport slave (
    input  A, B, en,
    output C, diff, diff_idx, c_q, diff_q, valid_q, eq_cnt, cmp_cnt
  );
endinterface

// File: rtl/a_equal_b.sv
// ALU-side equality comparator.
// C is the zero-extended (A==B) flag for the ALU result bus; diff/diff_idx
// locate the mismatching bits. c_q/diff_q/valid_q capture the compare on
// en-qualified edges for downstream flag logic.
// Optional macro AEQB_STATS_EN adds saturating eq_cnt/cmp_cnt statistics;
// without it both counters are tied to zero and no counter flops exist.
module a_equal_b #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  a_equal_b_if.slave  bus
);

  localparam int IDX_W = $clog2(WIDTH);

  logic             w_eq;
  logic [WIDTH-1:0] w_diff;
  logic             r_c_q;
  logic [WIDTH-1:0] r_diff_q;
  logic             r_valid_q;

  // Lowest set bit wins; an all-zero vector reports index 0.
  function automatic logic [IDX_W-1:0] lowest_set_idx(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Plain == keeps X/Z on the operands visible on C instead of masking it.
  assign w_eq          = (bus.A == bus.B);
  assign w_diff        = bus.A ^ bus.B;
  assign bus.C         = {{(WIDTH-1){1'b0}}, w_eq};
  assign bus.diff      = w_diff;
  assign bus.diff_idx  = lowest_set_idx(w_diff);

  // Capture the compare result and mismatch mask on en; hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c_q     <= 1'b0;
      r_diff_q  <= '0;
      r_valid_q <= 1'b0;
    end else if (bus.en) begin
      r_c_q     <= w_eq;
      r_diff_q  <= w_diff;
      r_valid_q <= 1'b1;
    end
  end

  assign bus.c_q     = r_c_q;
  assign bus.diff_q  = r_diff_q;
  assign bus.valid_q = r_valid_q;

`ifdef AEQB_STATS_EN
  logic [CNT_W-1:0] r_eq_cnt;
  logic [CNT_W-1:0] r_cmp_cnt;

  // Counters stick at all-ones so long runs never wrap back to small values.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Count every capture, and separately the captures that compared equal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_eq_cnt  <= '0;
      r_cmp_cnt <= '0;
    end else if (bus.en) begin
      r_cmp_cnt <= sat_inc(r_cmp_cnt);
      if (w_eq) r_eq_cnt <= sat_inc(r_eq_cnt);
    end
  end

  assign bus.eq_cnt  = r_eq_cnt;
  assign bus.cmp_cnt = r_cmp_cnt;
`else
  assign bus.eq_cnt  = {CNT_W{1'b0}};
  assign bus.cmp_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_a_equal_b.sv
// Scoreboard bench for a_equal_b (WIDTH=6, CNT_W=2).
// Stimulus pushes expected responses from a behavioural model into queues;
// monitor processes pop and compare against the DUT.
module tb_a_equal_b;

  localparam int WIDTH   = 6;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef AEQB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [5:0] a, b, c, diff;
    logic [2:0] idx;
    logic       cq;
    logic [5:0] dq;
    logic       vq;
    logic [1:0] eqc, cmpc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  a_equal_b_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  a_equal_b #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  exp_t sq[$];
  bit   clk_phase = 1'b0;
  event sweep_ev;

  // Behavioural model state: what the registered outputs should hold.
  int         m_cq = 0, m_vq = 0, m_eqc = 0, m_cmpc = 0;
  logic [5:0] m_dq = '0;
  logic [5:0] p_a = '0, p_b = '0;
  logic       p_en = 1'b0, p_rst = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare(input exp_t e);
    chk("C",        32'(bus.C),        32'(e.c));
    chk("diff",     32'(bus.diff),     32'(e.diff));
    chk("diff_idx", 32'(bus.diff_idx), 32'(e.idx));
    chk("c_q",      32'(bus.c_q),      32'(e.cq));
    chk("diff_q",   32'(bus.diff_q),   32'(e.dq));
    chk("valid_q",  32'(bus.valid_q),  32'(e.vq));
    chk("eq_cnt",   32'(bus.eq_cnt),   32'(e.eqc));
    chk("cmp_cnt",  32'(bus.cmp_cnt),  32'(e.cmpc));
  endtask

  // Expected response built from the definition, not from the RTL structure.
  function automatic exp_t make_exp(input logic [5:0] a, input logic [5:0] b);
    exp_t e;
    int   first;
    e.a    = a;
    e.b    = b;
    e.c    = (a == b) ? 6'd1 : 6'd0;
    e.diff = a ^ b;
    first  = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (((a >> i) & 6'd1) != ((b >> i) & 6'd1)) begin
        first = i;
        break;
      end
    end
    e.idx  = 3'(first);
    e.cq   = (m_cq != 0);
    e.dq   = m_dq;
    e.vq   = (m_vq != 0);
    e.eqc  = STATS ? 2'(m_eqc)  : 2'd0;
    e.cmpc = STATS ? 2'(m_cmpc) : 2'd0;
    return e;
  endfunction

  // Clocked monitor: one expected item per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (clk_phase && q.size() > 0) compare(q.pop_front());
  end

  // Combinational-sweep monitor, triggered 25 units after each application.
  always @(sweep_ev) begin
    if (sq.size() > 0) compare(sq.pop_front());
  end

  // One cycle: account for the edge just taken, then apply new inputs.
  task automatic step(input logic [5:0] a, input logic [5:0] b,
                      input logic e, input logic r);
    @(posedge clk);
    #2;
    if (!p_rst && p_en) begin
      m_cq   = (p_a == p_b) ? 1 : 0;
      m_dq   = p_a ^ p_b;
      m_vq   = 1;
      m_cmpc = (m_cmpc < CNT_MAX) ? m_cmpc + 1 : CNT_MAX;
      if (p_a == p_b) m_eqc = (m_eqc < CNT_MAX) ? m_eqc + 1 : CNT_MAX;
    end
    bus.A  = a;
    bus.B  = b;
    bus.en = e;
    rst    = r;
    if (r) begin
      m_cq = 0; m_dq = '0; m_vq = 0; m_eqc = 0; m_cmpc = 0;
    end
    p_a = a; p_b = b; p_en = e; p_rst = r;
    q.push_back(make_exp(a, b));
  endtask

  int sw_a[10] = '{5, 2, 13, -15, 19, -3, -25, -15, 12, 7};
  int sw_b[10] = '{3, 15, -24, 15, 19, -10, -4, -15, 4, 7};

  initial begin
    logic [5:0] ra, rb;
    logic       ren, rrst;
    bus.A  = '0;
    bus.B  = '0;
    bus.en = 1'b0;

    // Combinational sweep under reset: registered outputs must read zero.
    #3;
    for (int i = 0; i < 10; i++) begin
      bus.A = 6'(sw_a[i]);
      bus.B = 6'(sw_b[i]);
      sq.push_back(make_exp(6'(sw_a[i]), 6'(sw_b[i])));
      #25;
      ->sweep_ev;
      #10;
    end

    clk_phase = 1'b1;
    // Release reset and capture equal pairs until the counters saturate.
    step(6'd19, 6'd19, 1'b1, 1'b0);
    step(6'd7,  6'd7,  1'b1, 1'b0);
    step(6'd42, 6'd42, 1'b1, 1'b0);
    step(6'd0,  6'd0,  1'b1, 1'b0);
    step(6'd63, 6'd63, 1'b1, 1'b0);
    step(6'd12, 6'd4,  1'b1, 1'b0);
    step(6'd19, 6'd19, 1'b1, 1'b0);
    // Hold: en low with unequal operands keeps c_q while C drops.
    step(6'd5,  6'd3,  1'b0, 1'b0);
    step(6'd5,  6'd3,  1'b0, 1'b0);
    // Asynchronous reset between edges, then first en after release.
    step(6'd9,  6'd9,  1'b1, 1'b1);
    step(6'd9,  6'd9,  1'b1, 1'b0);
    step(6'd1,  6'd2,  1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      ra   = 6'($urandom_range(0, 63));
      rb   = ($urandom_range(0, 2) == 0) ? ra : 6'($urandom_range(0, 63));
      ren  = ($urandom_range(0, 3) != 0);
      rrst = ($urandom_range(0, 39) == 0);
      step(ra, rb, ren, rrst);
    end
    step(6'd33, 6'd33, 1'b1, 1'b1);
    step(6'd33, 6'd33, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover: got %0d unchecked items expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
